// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared constants and types for the fetch stage controller and its PC register.
// Used by fetch_stage_ctrl (optional perf counters under FETCH_PERF_COUNT_EN).
package fetch_stage_ctrl_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SEL_RESET,
      PC_SEL_BRANCH,
      PC_SEL_HOLD,
      PC_SEL_INC
   } pc_sel_e;

   // Sequential fetch address; wraps modulo 2^32 without any flag.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_stage_ctrl_pc_reg.sv
// Program counter register with next-PC selection: reset, branch redirect,
// hazard hold, or sequential increment.
module pc_reg
   import fetch_stage_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pcwrite,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc
);

   pc_sel_e     sel;
   logic [31:0] pc_next;

   // Priority: reset beats a taken branch, which beats the hazard hold.
   always_comb begin
      sel     = PC_SEL_INC;
      pc_next = pc_inc(pc);
      if (!rst_n)             sel = PC_SEL_RESET;
      else if (branch_taken)  sel = PC_SEL_BRANCH;
      else if (!pcwrite)      sel = PC_SEL_HOLD;

      case (sel)
         PC_SEL_RESET:  pc_next = RESET_PC;
         PC_SEL_BRANCH: pc_next = branch_target;
         PC_SEL_HOLD:   pc_next = pc;
         default:       pc_next = pc_inc(pc);
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      pc <= pc_next;
   end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF stage control: PC, IF/ID register, ID/EX bubble request and stall watchdog.
// Define FETCH_PERF_COUNT_EN to add stall_cycles / flush_count outputs.
module fetch_stage_ctrl
   import fetch_stage_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          MAX_STALL = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pcwrite,
   input  logic        if_id_write,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        id_ex_bubble,
   output logic        stall_error
`ifdef FETCH_PERF_COUNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   localparam int                CNT_W   = $clog2(MAX_STALL + 2);
   localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MAX_STALL + 1);

   logic [CNT_W-1:0] stall_run;
   logic [CNT_W-1:0] stall_run_next;
   logic             err_set;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .pcwrite      (pcwrite),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .pc           (pc_out)
   );

   // Error is raised on the same edge the run first exceeds MAX_STALL.
   always_comb begin
      stall_run_next = '0;
      err_set        = 1'b0;
      if (stall && !branch_taken) begin
         stall_run_next = (stall_run == CNT_SAT) ? CNT_SAT : stall_run + CNT_W'(1);
         err_set        = (stall_run_next == CNT_SAT) || pcwrite || if_id_write;
      end
   end

   // NOTE: reset is synchronous, so it lives inside the clocked branch only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_id_pc     <= '0;
         if_id_instr  <= NOP_INSTR;
         if_id_valid  <= 1'b0;
         id_ex_bubble <= 1'b1;
         stall_error  <= 1'b0;
         stall_run    <= '0;
      end else begin
         id_ex_bubble <= stall | branch_taken;
         stall_run    <= stall_run_next;
         if (err_set) stall_error <= 1'b1;

         if (branch_taken) begin
            if_id_pc    <= branch_target;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else if (if_id_write) begin
            if_id_pc    <= pc_inc(pc_out);
            if_id_instr <= instr_in;
            if_id_valid <= 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall)        stall_cycles <= stall_cycles + 32'd1;
         if (branch_taken) flush_count  <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed scenarios plus randomized
// hazard/branch traffic compared against a behavioural model each cycle.
module tb_fetch_stage_ctrl;

   localparam int          MAX_STALL = 4;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        pcwrite;
   logic        if_id_write;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr_in;
   logic [31:0] pc_out;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        id_ex_bubble;
   logic        stall_error;
`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [31:0] m_pc, m_if_pc, m_if_instr, m_sc, m_fc;
   logic        m_if_valid, m_bubble, m_err;
   int          m_run;

   fetch_stage_ctrl #(.RESET_PC(RESET_PC), .MAX_STALL(MAX_STALL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pcwrite      (pcwrite),
      .if_id_write  (if_id_write),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .instr_in     (instr_in),
      .pc_out       (pc_out),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .if_id_valid  (if_id_valid),
      .id_ex_bubble (id_ex_bubble),
      .stall_error  (stall_error)
`ifdef FETCH_PERF_COUNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model: what one rising edge does, stated directly from the behaviour rules.
   task automatic model_edge(input logic r, pcw, ifw, st, br,
                             input logic [31:0] tgt, instr);
      if (!r) begin
         m_pc = RESET_PC; m_if_pc = 0; m_if_instr = 0; m_if_valid = 0;
         m_bubble = 1; m_err = 0; m_run = 0; m_sc = 0; m_fc = 0;
      end else begin
         m_bubble = st | br;
         if (st) m_sc = m_sc + 1;
         if (br) m_fc = m_fc + 1;
         if (br) begin
            m_if_pc = tgt; m_if_instr = 0; m_if_valid = 0;
            m_pc = tgt; m_run = 0;
         end else begin
            if (ifw) begin
               m_if_pc = m_pc + 4; m_if_instr = instr; m_if_valid = 1;
            end
            if (pcw) m_pc = m_pc + 4;
            if (st) begin
               m_run++;
               if (m_run > MAX_STALL) m_err = 1;
               if (pcw || ifw) m_err = 1;
            end else begin
               m_run = 0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc_out"},       pc_out,              m_pc);
      check({tag, ".if_id_pc"},     if_id_pc,            m_if_pc);
      check({tag, ".if_id_instr"},  if_id_instr,         m_if_instr);
      check({tag, ".if_id_valid"},  {31'b0, if_id_valid},  {31'b0, m_if_valid});
      check({tag, ".id_ex_bubble"}, {31'b0, id_ex_bubble}, {31'b0, m_bubble});
      check({tag, ".stall_error"},  {31'b0, stall_error},  {31'b0, m_err});
`ifdef FETCH_PERF_COUNT_EN
      check({tag, ".stall_cycles"}, stall_cycles, m_sc);
      check({tag, ".flush_count"},  flush_count,  m_fc);
`endif
   endtask

   // Drive inputs, take one edge, sample 1 time unit later.
   task automatic step(input string tag, input logic r, pcw, ifw, st, br,
                       input logic [31:0] tgt, instr);
      rst_n = r; pcwrite = pcw; if_id_write = ifw; stall = st;
      branch_taken = br; branch_target = tgt; instr_in = instr;
      @(posedge clk);
      model_edge(r, pcw, ifw, st, br, tgt, instr);
      #1;
      check_all(tag);
   endtask

   initial begin
      m_run = 0;
      // Reset applied with a branch pending: reset must win.
      step("reset", 0, 1, 1, 1, 1, 32'h1234_5678, 32'hDEAD_BEEF);
      check("reset.pc_const", pc_out, RESET_PC);
      check("reset.bubble_const", {31'b0, id_ex_bubble}, 32'd1);

      // Three free cycles from RESET_PC
      step("free1", 1, 1, 1, 0, 0, 0, 32'h2001_0005);
      check("free1.pc_const", pc_out, 32'h4);
      step("free2", 1, 1, 1, 0, 0, 0, 32'h2001_0005);
      check("free2.pc_const", pc_out, 32'h8);
      check("free2.if_pc_const", if_id_pc, 32'h8);
      check("free2.valid_const", {31'b0, if_id_valid}, 32'd1);
      step("free3", 1, 1, 1, 0, 0, 0, 32'h2001_0005);
      check("free3.pc_const", pc_out, 32'hC);

      // Reach pc=0x40 with a valid IF/ID, then one consistent stall
      step("br3c", 1, 1, 1, 0, 1, 32'h3C, 32'h1111_1111);
      step("to40", 1, 1, 1, 0, 0, 0, 32'h2222_2222);
      check("to40.pc_const", pc_out, 32'h40);
      step("stall1", 1, 0, 0, 1, 0, 0, 32'h3333_3333);
      check("stall1.pc_const", pc_out, 32'h40);
      check("stall1.instr_const", if_id_instr, 32'h2222_2222);
      check("stall1.bubble_const", {31'b0, id_ex_bubble}, 32'd1);

      // Branch concurrent with stall
      step("brstall", 1, 0, 0, 1, 1, 32'h100, 32'h4444_4444);
      check("brstall.pc_const", pc_out, 32'h100);
      check("brstall.valid_const", {31'b0, if_id_valid}, 32'd0);

      // PC wrap
      step("brwrap", 1, 1, 1, 0, 1, 32'hFFFF_FFFC, 0);
      step("wrap", 1, 1, 1, 0, 0, 0, 32'h5555_5555);
      check("wrap.pc_const", pc_out, 32'h0);
      check("wrap.if_pc_const", if_id_pc, 32'h0);

      // Unaligned branch target passes through unchanged
      step("brodd", 1, 1, 1, 0, 1, 32'h0000_0203, 0);
      step("odd", 1, 1, 1, 0, 0, 0, 32'h6666_6666);
      check("odd.pc_const", pc_out, 32'h207);

      // Watchdog: 4 stalls fine, 5th sets the sticky error
      for (int i = 0; i < 4; i++) step("wd_ok", 1, 0, 0, 1, 0, 0, 32'h7);
      check("wd4.err_const", {31'b0, stall_error}, 32'd0);
      step("wd5", 1, 0, 0, 1, 0, 0, 32'h7);
      check("wd5.err_const", {31'b0, stall_error}, 32'd1);
      for (int i = 0; i < 3; i++) step("wd_sticky", 1, 1, 1, 0, 0, 0, 32'h8);
      check("wd_sticky.err_const", {31'b0, stall_error}, 32'd1);
      step("wd_reset", 0, 1, 1, 0, 0, 0, 0);
      check("wd_reset.err_const", {31'b0, stall_error}, 32'd0);

      // Stall interrupted by a branch restarts the run
      for (int i = 0; i < 3; i++) step("run_a", 1, 0, 0, 1, 0, 0, 32'h9);
      step("run_br", 1, 0, 0, 1, 1, 32'h80, 0);
      for (int i = 0; i < 4; i++) step("run_b", 1, 0, 0, 1, 0, 0, 32'h9);
      check("run_b.err_const", {31'b0, stall_error}, 32'd0);

      // Inconsistent hazard controls
      step("incons", 1, 1, 0, 1, 0, 0, 32'hA);
      check("incons.err_const", {31'b0, stall_error}, 32'd1);

      // Reset mid-stall discards the held instruction
      step("pre", 0, 1, 1, 0, 0, 0, 0);
      step("fill", 1, 1, 1, 0, 0, 0, 32'hBBBB_BBBB);
      step("hold", 1, 0, 0, 1, 0, 0, 32'hCCCC_CCCC);
      step("midrst", 0, 0, 0, 1, 1, 32'h500, 0);
      check("midrst.instr_const", if_id_instr, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         int unsigned sel;
         logic r, pcw, ifw, st, br;
         sel = $urandom_range(0, 99);
         r = 1; pcw = 1; ifw = 1; st = 0; br = 0;
         if (sel < 3) begin
            r = 0; st = 1'($urandom); br = 1'($urandom);
         end else if (sel < 35) begin
            pcw = 0; ifw = 0; st = 1; br = ($urandom_range(0, 9) == 0);
         end else if (sel < 39) begin
            st = 1; pcw = 1'($urandom); ifw = ~pcw | 1'($urandom);
         end else if (sel < 52) begin
            br = 1; st = 1'($urandom); pcw = 1'($urandom); ifw = 1'($urandom);
         end else if (sel < 62) begin
            pcw = 0; ifw = 1'($urandom);
         end
         step("rand", r, pcw, ifw, st, br, $urandom, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_stage_ctrl.md
FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MAX_STALL, default 4, longest legal run of consecutive stall cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pcwrite  input  1  hazard-unit PC write enable; 0 holds PC.
REQ-006 if_id_write  input  1  hazard-unit IF/ID write enable; 0 holds IF/ID.
REQ-007 stall  input  1  hazard-unit bubble request for ID/EX.
REQ-008 branch_taken  input  1  EX-stage branch/jump resolved taken.
REQ-009 branch_target  input  32  redirect address, valid with branch_taken.
REQ-010 instr_in  input  32  instruction memory read data for pc_out.
REQ-011 pc_out  output  32  current fetch address to instruction memory.
REQ-012 if_id_pc  output  32  PC+4 of instruction held in IF/ID.
REQ-013 if_id_instr  output  32  instruction held in IF/ID.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-015 id_ex_bubble  output  1  registered; ID/EX shall load zero control next edge.
REQ-016 stall_error  output  1  sticky protocol/watchdog error flag.

Function
REQ-017 Normal cycle (pcwrite=1, if_id_write=1, no branch): pc_out <= pc_out+4; IF/ID <= {pc_out+4, instr_in, valid=1}.
REQ-018 PC addition is 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-019 pcwrite=0 holds pc_out; if_id_write=0 holds if_id_pc, if_id_instr, if_id_valid.
REQ-020 id_ex_bubble <= stall | branch_taken each edge; one-cycle latency, no combinational path to output.
REQ-021 branch_taken=1 overrides pcwrite/if_id_write: pc_out <= branch_target; IF/ID <= {branch_target, 32'h0000_0000, valid=0}.
REQ-022 Branch and stall in the same cycle: branch behaviour per REQ-021 applies, stall run counter clears.
REQ-023 Stall run counter: increments each cycle stall=1 and branch_taken=0, saturates at MAX_STALL+1, clears when stall=0.
REQ-024 stall_error sets when stall run counter exceeds MAX_STALL (catches a held hazard unit).
REQ-025 stall_error sets when stall=1 with pcwrite=1 or if_id_write=1 (inconsistent hazard controls), checked only when branch_taken=0.
REQ-026 stall_error clears only on reset.
REQ-027 branch_target low two bits are used unmodified; misalignment is not checked.

Reset
REQ-028 rst_n=0 at an edge: pc_out=RESET_PC, if_id_pc=0, if_id_instr=32'h0, if_id_valid=0, id_ex_bubble=1, stall_error=0, counters=0.
REQ-029 Reset overrides all inputs including branch_taken; reset mid-stall discards the held instruction.
REQ-030 First edge with rst_n=1 fetches from RESET_PC per REQ-017.

Configuration
REQ-031 Macro FETCH_PERF_COUNT_EN: when defined, adds outputs stall_cycles[31:0] and flush_count[31:0], incremented on each stall=1 cycle and each branch_taken=1 cycle, wrapping modulo 2^32, zeroed on reset.
REQ-032 Without FETCH_PERF_COUNT_EN the counter outputs and registers do not exist; all other behaviour is identical.

Structure
REQ-033 Shared package holds NOP_INSTR (32'h0), PC_STEP (4) and the default RESET_PC constant.
REQ-034 One sub-module pc_reg holds the PC register with next-PC mux (reset, branch, hold, increment).
REQ-035 IF/ID register, bubble register, watchdog and counters live in fetch_stage_ctrl.

Verification
REQ-036 Reset then 3 free cycles, instr_in=32'h2001_0005 -> pc_out 0,4,8,C; if_id_pc=32'h8, if_id_valid=1.
REQ-037 pc_out=32'h40, pcwrite=0, if_id_write=0, stall=1 for 1 cycle -> pc_out and IF/ID unchanged, id_ex_bubble=1 next cycle, stall_error=0.
REQ-038 branch_taken=1, branch_target=32'h100, concurrent stall=1 -> pc_out=32'h100, if_id_instr=0, if_id_valid=0, id_ex_bubble=1.
REQ-039 stall=1 with holds for 5 consecutive cycles (MAX_STALL=4) -> stall_error=1 after fifth edge, stays 1 until rst_n=0.
REQ-040 stall=1 with pcwrite=1 for one cycle -> stall_error=1; with FETCH_PERF_COUNT_EN stall_cycles=1.
REQ-041 pc_out=32'hFFFF_FFFC, free cycle -> pc_out=32'h0, if_id_pc=32'h0.
